// File: rtl/sim_block_dev.sv
// Behavioural block-device model serving the CADR bd_* disk interface from an internal sector array.
// Define SIM_BD_STALL_EN to drop bd_iordy for one cycle after every 16 words of a transfer.
module sim_block_dev #(
  parameter int    SECTOR_WORDS = 256,
  parameter int    NUM_SECTORS  = 1024,
  parameter int    LATENCY      = 8,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  bd_cmd,
  input  logic        bd_start,
  input  logic [23:0] bd_addr,
  input  logic [15:0] bd_data_in,
  input  logic        bd_rd,
  input  logic        bd_wr,
  output logic        bd_bsy,
  output logic        bd_rdy,
  output logic        bd_err,
  output logic        bd_iordy,
  output logic [15:0] bd_data_out,
  output logic [2:0]  dbg_state
);
  // Handshake: a word moves on a clk edge where bd_iordy=1 and the strobe matching the
  // transfer direction is 1 (bd_rd in RXFER, bd_wr in WXFER); every other strobe is ignored.

  localparam int SH     = $clog2(SECTOR_WORDS);
  localparam int IDX_W  = (SH > 0) ? SH : 1;
  localparam int DEPTH  = SECTOR_WORDS * NUM_SECTORS;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(LATENCY + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECTOR_WORDS - 1);

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_ILL = 2'b11;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_IDLE  = 3'd1,
    S_SEEK  = 3'd2,
    S_RXFER = 3'd3,
    S_WXFER = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [1:0]        cmd_q;
  logic [23:0]       addr_q;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_inc;
  logic [CNT_W-1:0]  cnt;
  logic [MEM_AW-1:0] base;
  logic [MEM_AW-1:0] word_addr;
  logic [MEM_AW-1:0] next_addr;
  logic              in_range;
  logic              stall_point;
  logic              mem_we;
  logic [15:0]       mem [DEPTH];

  assign idx_inc   = idx + 1'b1;
  assign base      = MEM_AW'(addr_q) << SH;
  assign word_addr = base + MEM_AW'(idx);
  assign next_addr = base + MEM_AW'(idx_inc);
  assign in_range  = {8'd0, addr_q} < 32'(NUM_SECTORS);
  assign dbg_state = state;

`ifdef SIM_BD_STALL_EN
  logic [31:0] idx_inc32;
  assign idx_inc32   = 32'(idx_inc);
  assign stall_point = (idx_inc32[3:0] == 4'd0);
`else
  assign stall_point = 1'b0;
`endif

  assign mem_we = !reset && (state == S_WXFER) && bd_iordy && bd_wr;

  // The array is deliberately outside the reset domain so a reset never disturbs stored sectors.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_addr] <= bd_data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RESET;
      bd_bsy      <= 1'b0;
      bd_rdy      <= 1'b0;
      bd_err      <= 1'b0;
      bd_iordy    <= 1'b0;
      bd_data_out <= '0;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      idx         <= '0;
      cnt         <= '0;
    end else begin
      unique case (state)
        S_RESET: begin
          state  <= S_IDLE;
          bd_rdy <= 1'b1;
        end
        S_IDLE: begin
          if (bd_start) begin
            cmd_q  <= bd_cmd;
            addr_q <= bd_addr;
            idx    <= '0;
            cnt    <= CNT_W'(LATENCY + 1);
            bd_err <= 1'b0;
            state  <= (bd_cmd == CMD_NOP) ? S_DONE : S_SEEK;
          end
        end
        S_SEEK: begin
          bd_bsy <= 1'b1;
          bd_rdy <= 1'b0;
          // Loaded with LATENCY+1 so the first word lands LATENCY+2 edges after acceptance.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (cmd_q == CMD_ILL || !in_range) begin
            state  <= S_DONE;
            bd_err <= 1'b1;
            bd_bsy <= 1'b0;
          end else if (cmd_q == CMD_RD) begin
            state       <= S_RXFER;
            bd_iordy    <= 1'b1;
            bd_data_out <= mem[word_addr];
          end else begin
            state    <= S_WXFER;
            bd_iordy <= 1'b1;
          end
        end
        S_RXFER: begin
          if (!bd_iordy) begin
            bd_iordy <= 1'b1;
          end else if (bd_rd) begin
            if (idx == LAST_IDX) begin
              state    <= S_DONE;
              bd_iordy <= 1'b0;
            end else begin
              idx         <= idx_inc;
              bd_data_out <= mem[next_addr];
              bd_iordy    <= !stall_point;
            end
          end
        end
        S_WXFER: begin
          if (!bd_iordy) begin
            bd_iordy <= 1'b1;
          end else if (bd_wr) begin
            if (idx == LAST_IDX) begin
              state    <= S_DONE;
              bd_iordy <= 1'b0;
            end else begin
              idx      <= idx_inc;
              bd_iordy <= !stall_point;
            end
          end
        end
        S_DONE: begin
          bd_bsy   <= 1'b0;
          bd_iordy <= 1'b0;
          // A held start parks here so one request never runs twice.
          if (!bd_start) begin
            state  <= S_IDLE;
            bd_rdy <= 1'b1;
          end else begin
            bd_rdy <= 1'b0;
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule
